// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Default widths match the if_fetch_buffer parameter defaults.
package if_pkg;

    localparam int IF_ADDR_W  = 64;
    localparam int IF_INSTR_W = 32;

    localparam logic [IF_ADDR_W-1:0] IF_RESET_ADDR = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries.
// Clear has priority over push/pop; pushes when full and pops when empty are ignored.
module if_fifo #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; consumers only look at it when count is non-zero.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch buffer: issues one instruction-memory request at a time and queues responses for decode.
// Optional macro IF_FETCH_BUFFER_BYPASS_EN lets a response reach decode in its arrival cycle when the queue is empty.
//
// state   | meaning
// IDLE    | no request outstanding; may issue when a slot is free
// WAIT    | request accepted, waiting for its response
// DISCARD | flushed while waiting; next response is dropped
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic                   flush,
    output logic                   if_buffer_stall,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0]  id_pc
);

    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic [EW-1:0]         w_head;
    logic                  w_accept;
    logic                  w_rsp_take;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bypass;

    // A request only goes out with a free slot, so the eventual push always fits.
    assign imem_req_valid  = !reset && (r_state == IDLE) && !flush && !w_full;
    assign w_accept        = imem_req_valid && imem_req_ready;
    assign if_buffer_stall = reset || (!flush && !w_accept);
    assign imem_req_addr   = pc;

    assign w_rsp_take = (r_state == WAIT) && imem_rsp_valid && !flush;

`ifdef IF_FETCH_BUFFER_BYPASS_EN
    assign w_bypass = w_empty && w_rsp_take;
    assign w_push   = w_rsp_take && !(w_bypass && id_ready);
`else
    assign w_bypass = 1'b0;
    assign w_push   = w_rsp_take;
`endif

    assign w_pop    = !reset && (w_count != '0) && id_ready && !flush;
    assign id_valid = !reset && ((w_count != '0) || w_bypass);
    assign id_instr = reset    ? '0 :
                      w_bypass ? imem_rsp_data : w_head[INSTR_WIDTH-1:0];
    assign id_pc    = reset    ? '0 :
                      w_bypass ? r_pc : w_head[EW-1:INSTR_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= ADDR_WIDTH'(IF_RESET_ADDR);
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_pc <= pc;
        end
    end

    // A response arriving with a flush still retires the outstanding request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = WAIT;
            WAIT: begin
                if (flush)               w_state_nxt = imem_rsp_valid ? IDLE : DISCARD;
                else if (imem_rsp_valid) w_state_nxt = IDLE;
            end
            DISCARD: if (imem_rsp_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    if_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({r_pc, imem_rsp_data}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Scoreboard bench for if_fetch_buffer: responses push expected entries, decode pops compare them.
// Bypass checks are compiled in when IF_FETCH_BUFFER_BYPASS_EN is defined.
module tb_if_fetch_buffer;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc = '0;
    logic        flush = 1'b0;
    logic        if_buffer_stall;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [63:0] id_pc;

    int checks = 0;
    int errors = 0;
    fetch_entry_t exp_q[$];

    always #5 clk = ~clk;

    if_fetch_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .flush           (flush),
        .if_buffer_stall (if_buffer_stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc)
    );

    // Scoreboard pop at the falling edge, then advance past the rising edge.
    task automatic cycle();
        fetch_entry_t e;
        @(negedge clk);
        if (!reset && id_valid && id_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pop got pc=%h instr=%h required no entry", id_pc, id_instr);
            end else begin
                e = exp_q.pop_front();
                if (id_pc !== e.pc || id_instr !== e.instr) begin
                    errors++;
                    $display("FAIL sb_entry got pc=%h instr=%h required pc=%h instr=%h",
                             id_pc, id_instr, e.pc, e.instr);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [63:0] addr, input logic [31:0] data, input int dly);
        fetch_entry_t e;
        int n;
        n = 0;
        pc = addr;
        imem_req_ready = 1'b1;
        #1;
        while (!imem_req_valid && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== addr) begin
            errors++;
            $display("FAIL fetch_req got valid=%b addr=%h required valid=1 addr=%h",
                     imem_req_valid, imem_req_addr, addr);
        end
        cycle();
        imem_req_ready = 1'b0;
        repeat (dly) cycle();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        e.pc = addr;
        e.instr = data;
        exp_q.push_back(e);
        cycle();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_buffer_stall !== 1'b1 || id_valid !== 1'b0 ||
            id_instr !== 32'h0 || id_pc !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs got req_valid=%b stall=%b id_valid=%b instr=%h pc=%h required 0 1 0 0 0",
                     imem_req_valid, if_buffer_stall, id_valid, id_instr, id_pc);
        end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        fetch_entry_t e;
        id_ready = 1'b0;
        pc = 64'h1000;
        imem_req_ready = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000 || if_buffer_stall !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept got valid=%b addr=%h stall=%b required 1 1000 0",
                     imem_req_valid, imem_req_addr, if_buffer_stall);
        end
        cycle();
        imem_req_ready = 1'b0;
        pc = 64'h1004;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        e.pc = 64'h1000;
        e.instr = 32'h0000_0013;
        exp_q.push_back(e);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_buffer_stall !== 1'b1) begin
            errors++;
            $display("FAIL basic_wait got valid=%b stall=%b required 0 1", imem_req_valid, if_buffer_stall);
        end
`ifndef IF_FETCH_BUFFER_BYPASS_EN
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_bypass got id_valid=%b required 0", id_valid);
        end
`endif
        cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 64'h1000 || id_instr !== 32'h0000_0013) begin
            errors++;
            $display("FAIL basic_out got valid=%b pc=%h instr=%h required 1 1000 00000013",
                     id_valid, id_pc, id_instr);
        end
        id_ready = 1'b1;
        cycle();
        id_ready = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain got id_valid=%b required 0", id_valid);
        end
    endtask

    task automatic test_full();
        fetch_entry_t e;
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) fetch_one(64'h1000 + 64'(4 * i), 32'hA000_0000 + 32'(i), 0);
        pc = 64'h1010;
        imem_req_ready = 1'b1;
        #1;
        checks++;
        if (dut.w_count !== 3'd4) begin
            errors++;
            $display("FAIL full_count got %0d required 4", dut.w_count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_valid !== 1'b0 || if_buffer_stall !== 1'b1) begin
                errors++;
                $display("FAIL full_hold got valid=%b stall=%b required 0 1", imem_req_valid, if_buffer_stall);
            end
            cycle();
        end
        id_ready = 1'b1;
        cycle();
        id_ready = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || if_buffer_stall !== 1'b0) begin
            errors++;
            $display("FAIL full_refill got valid=%b stall=%b required 1 0", imem_req_valid, if_buffer_stall);
        end
        cycle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hA000_0004;
        e.pc = 64'h1010;
        e.instr = 32'hA000_0004;
        exp_q.push_back(e);
        cycle();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || dut.w_count !== 3'd4) begin
            errors++;
            $display("FAIL full_once got valid=%b count=%0d required 0 4", imem_req_valid, dut.w_count);
        end
        imem_req_ready = 1'b0;
        id_ready = 1'b1;
        repeat (5) cycle();
        checks++;
        if (id_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain got id_valid=%b left=%0d required 0 0", id_valid, exp_q.size());
        end
    endtask

    task automatic test_flush_wait();
        id_ready = 1'b1;
        pc = 64'h1014;
        imem_req_ready = 1'b1;
        #1;
        cycle();
        imem_req_ready = 1'b0;
        flush = 1'b1;
        pc = 64'h2000;
        #1;
        checks++;
        if (if_buffer_stall !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushw_cycle got stall=%b valid=%b required 0 0", if_buffer_stall, imem_req_valid);
        end
        cycle();
        flush = 1'b0;
        #1;
        checks++;
        if (dut.r_state !== DISCARD || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushw_discard got state=%0d valid=%b required 2 0", dut.r_state, imem_req_valid);
        end
        cycle();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushw_drop got id_valid=%b required 0", id_valid);
        end
        cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (dut.r_state !== IDLE || id_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
            imem_req_addr !== 64'h2000) begin
            errors++;
            $display("FAIL flushw_redirect got state=%0d id_valid=%b valid=%b addr=%h required 0 0 1 2000",
                     dut.r_state, id_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_flush_rsp_pop();
        id_ready = 1'b0;
        fetch_one(64'h2000, 32'h1111_1111, 0);
        fetch_one(64'h2004, 32'h2222_2222, 1);
        pc = 64'h2008;
        imem_req_ready = 1'b1;
        #1;
        checks++;
        if (dut.w_count !== 3'd2) begin
            errors++;
            $display("FAIL flushr_pre got count=%0d required 2", dut.w_count);
        end
        cycle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_3333;
        flush = 1'b1;
        id_ready = 1'b1;
        pc = 64'h2400;
        cycle();
        exp_q.delete();
        imem_rsp_valid = 1'b0;
        flush = 1'b0;
        id_ready = 1'b0;
        #1;
        checks++;
        if (dut.w_count !== 3'd0 || dut.r_state !== IDLE || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushr_post got count=%0d state=%0d id_valid=%b required 0 0 0",
                     dut.w_count, dut.r_state, id_valid);
        end
    endtask

    task automatic test_reset_wait();
        id_ready = 1'b0;
        pc = 64'h3000;
        imem_req_ready = 1'b1;
        #1;
        cycle();
        imem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_buffer_stall !== 1'b1 || dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL rstw_assert got valid=%b stall=%b state=%0d required 0 1 0",
                     imem_req_valid, if_buffer_stall, dut.r_state);
        end
        cycle();
        exp_q.delete();
        reset = 1'b0;
        pc = 64'h4000;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h5555_5555;
        #1;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstw_stray got id_valid=%b required 0", id_valid);
        end
        cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (dut.w_count !== 3'd0 || id_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
            imem_req_addr !== 64'h4000) begin
            errors++;
            $display("FAIL rstw_after got count=%0d id_valid=%b valid=%b addr=%h required 0 0 1 4000",
                     dut.w_count, id_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_back_to_back();
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            fetch_one(64'h5000 + 64'(4 * i), $urandom, int'($urandom_range(0, 2)));
        cycle();
        cycle();
        checks++;
        if (exp_q.size() != 0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got left=%0d id_valid=%b required 0 0", exp_q.size(), id_valid);
        end
    endtask

`ifdef IF_FETCH_BUFFER_BYPASS_EN
    task automatic test_bypass();
        fetch_entry_t e;
        id_ready = 1'b1;
        pc = 64'h6000;
        imem_req_ready = 1'b1;
        #1;
        cycle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        e.pc = 64'h6000;
        e.instr = 32'hDEAD_BEEF;
        exp_q.push_back(e);
        #1;
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'hDEAD_BEEF || id_pc !== 64'h6000) begin
            errors++;
            $display("FAIL bypass_same got valid=%b instr=%h pc=%h required 1 deadbeef 6000",
                     id_valid, id_instr, id_pc);
        end
        cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (dut.w_count !== 3'd0) begin
            errors++;
            $display("FAIL bypass_count got %0d required 0", dut.w_count);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_flush_wait();
        test_flush_rsp_pop();
        test_reset_wait();
        test_back_to_back();
`ifdef IF_FETCH_BUFFER_BYPASS_EN
        test_bypass();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_buffer.md
IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, PC and address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >=2.
REQ-004 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port pc, input, ADDR_WIDTH, current fetch PC from the PC register.
REQ-007 SHALL have port flush, input, 1, redirect; discard all buffered and in-flight fetches.
REQ-008 SHALL have port if_buffer_stall, output, 1, holds the PC register when high.
REQ-009 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-010 SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-011 SHALL have port imem_req_addr, output, ADDR_WIDTH, request address, equal to pc.
REQ-012 SHALL have port imem_rsp_valid, input, 1, response data valid.
REQ-013 SHALL have port imem_rsp_data, input, INSTR_WIDTH, fetched instruction.
REQ-014 SHALL have port id_valid, output, 1, entry available to decode.
REQ-015 SHALL have port id_ready, input, 1, decode consumes entry.
REQ-016 SHALL have port id_instr, output, INSTR_WIDTH, head instruction.
REQ-017 SHALL have port id_pc, output, ADDR_WIDTH, PC of head instruction.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, DISCARD; at most one request outstanding.
REQ-019 imem_req_valid SHALL equal (state==IDLE) && !flush && (count<DEPTH).
REQ-020 A request handshake (valid&&ready) SHALL latch pc as the entry PC and move IDLE->WAIT.
REQ-021 if_buffer_stall SHALL equal !flush && !(imem_req_valid && imem_req_ready); the PC advances exactly once per accepted request.
REQ-022 In WAIT, imem_rsp_valid && !flush SHALL push {latched pc, imem_rsp_data} into the FIFO and move to IDLE.
REQ-023 id_valid SHALL equal count!=0; pop SHALL occur when id_valid && id_ready && !flush.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; FIFO order SHALL be preserved.
REQ-025 count SHALL never exceed DEPTH; requests are issued only with a free slot reserved.
REQ-026 Flush in IDLE SHALL clear the FIFO (count=0) next edge and keep IDLE.
REQ-027 Flush in WAIT without response SHALL clear the FIFO and move to DISCARD.
REQ-028 Flush in WAIT with same-cycle response SHALL drop the response, clear the FIFO and move to IDLE.
REQ-029 DISCARD SHALL drop the next response and move to IDLE; flush in DISCARD SHALL stay in DISCARD.
REQ-030 imem_rsp_valid outside WAIT/DISCARD SHALL be ignored.
REQ-031 Minimum latency without bypass: request accept to id_valid = rsp latency + 1 cycle.

Reset
REQ-032 Reset SHALL force state IDLE, count 0, FIFO pointers 0, latched PC 0.
REQ-033 During reset imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0, if_buffer_stall=1.
REQ-034 Reset mid-WAIT SHALL abandon the in-flight request; later stray responses are ignored per REQ-030.

Configuration
REQ-035 Macro IF_FETCH_BUFFER_BYPASS_EN defined: when count==0 and a non-flushed response arrives in WAIT, id_valid SHALL assert that cycle with id_instr=imem_rsp_data, id_pc=latched pc; if id_ready is also high the entry SHALL NOT be pushed.
REQ-036 Macro undefined: all responses SHALL pass through the FIFO (REQ-031 latency).

Structure
REQ-037 Package if_pkg SHALL hold fetch_state_t enum, fetch_entry_t struct {pc, instr}, and the reset address constant.
REQ-038 Storage SHALL be sub-module if_fifo (synchronous FIFO, count/full/empty, synchronous clear).

Verification
REQ-039 Reset, pc=0x1000, ready=1, rsp 1 cycle later data 0x00000013, id_ready=1 -> id_valid with id_pc=0x1000, id_instr=0x00000013; stall low only on accept cycle.
REQ-040 id_ready=0, fetch 0x1000..0x100C -> count=4, imem_req_valid=0, if_buffer_stall=1 held; one pop -> one new request issued.
REQ-041 Flush in WAIT with rsp 2 cycles later -> state DISCARD, response dropped, id_valid=0, next request uses redirect pc 0x2000.
REQ-042 Flush coincident with response and pop, count=2 -> count=0, state IDLE, no push.
REQ-043 Assert reset during WAIT, release, inject stray rsp -> ignored, id_valid=0, first new request address = pc.
REQ-044 With IF_FETCH_BUFFER_BYPASS_EN, empty FIFO, rsp 0xDEADBEEF with id_ready=1 -> id_valid same cycle, count stays 0.
